// File: rtl/caster_bus_pkg.sv
// Shared definitions for the caster bus initiator: FSM state encoding and
// the bit positions of the three caster enables.
package caster_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } cbm_state_t;

  localparam int CASTER_IFMAP = 0;
  localparam int CASTER_FLTR  = 1;
  localparam int CASTER_PSUM  = 2;
  localparam int CASTER_EN_W  = 3;

endpackage

// File: rtl/caster_bus_master_if.sv
// Buffer-side streams and caster-side bus of one MultiCaster initiator.
// The master modport is the initiator; slave is the buffer/caster side.
interface caster_bus_master_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]   ifmap_in_data;
  logic                    ifmap_in_valid;
  logic                    ifmap_in_ready;
  logic [DATA_WIDTH-1:0]   fltr_in_data;
  logic                    fltr_in_valid;
  logic                    fltr_in_ready;
  logic [2*DATA_WIDTH-1:0] psum_in_data;
  logic                    psum_in_valid;
  logic                    psum_in_ready;
  logic [2*DATA_WIDTH-1:0] psum_out_data;
  logic                    psum_out_valid;
  logic                    psum_out_ready;
  logic [DATA_WIDTH-1:0]   ifmap_data_B2M;
  logic [DATA_WIDTH-1:0]   fltr_data_B2M;
  logic [2*DATA_WIDTH-1:0] psum_data_B2M;
  logic [2*DATA_WIDTH-1:0] psum_data_M2B;
  logic [2:0]              caster_en;
  logic                    caster_ready;
  logic                    caster_valid;

  modport master (
    input  ifmap_in_data, ifmap_in_valid, fltr_in_data, fltr_in_valid,
    input  psum_in_data, psum_in_valid, psum_out_ready,
    input  psum_data_M2B, caster_ready, caster_valid,
    output ifmap_in_ready, fltr_in_ready, psum_in_ready,
    output psum_out_data, psum_out_valid,
    output ifmap_data_B2M, fltr_data_B2M, psum_data_B2M, caster_en
  );

  modport slave (
    output ifmap_in_data, ifmap_in_valid, fltr_in_data, fltr_in_valid,
    output psum_in_data, psum_in_valid, psum_out_ready,
    output psum_data_M2B, caster_ready, caster_valid,
    input  ifmap_in_ready, fltr_in_ready, psum_in_ready,
    input  psum_out_data, psum_out_valid,
    input  ifmap_data_B2M, fltr_data_B2M, psum_data_B2M, caster_en
  );
endinterface

// File: rtl/caster_bus_master.sv
// Caster bus initiator: joins ifmap/filter/psum words, issues them to the
// MultiCaster, waits for the result and returns it, for pass_len passes.
module caster_bus_master
  import caster_bus_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_COL     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         pass_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  caster_bus_master_if.master bus
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  if (NUM_COL < 1) begin : g_bad_num_col
    $error("caster_bus_master: NUM_COL must be at least 1");
  end

  cbm_state_t            state_reg, state_next;
  logic [15:0]           pass_len_reg, pass_cnt_reg;
  logic [TW-1:0]         tmo_cnt_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] ifmap_b2m_reg, fltr_b2m_reg;
  logic [PW-1:0]         psum_b2m_reg, psum_out_reg;

  logic join_ok, accept, issue_go, wait_hit, tmo_hit, drain_hs, last_pass;

  assign join_ok   = bus.ifmap_in_valid & bus.fltr_in_valid & bus.psum_in_valid;
  assign accept    = (state_reg == FETCH) & join_ok;
  assign issue_go  = (state_reg == ISSUE) & bus.caster_ready;
  assign wait_hit  = (state_reg == WAIT) & bus.caster_valid;
  // A valid arriving on the last allowed cycle still wins over the timeout.
  assign tmo_hit   = (state_reg == WAIT) & ~bus.caster_valid & (tmo_cnt_reg == TMO_LAST);
  assign drain_hs  = (state_reg == DRAIN) & bus.psum_out_ready;
  assign last_pass = (pass_cnt_reg + 16'd1) == pass_len_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    bus.caster_en = '0;
    case (state_reg)
      IDLE:  if (start) state_next = (pass_len == 16'd0) ? DONE : FETCH;
      FETCH: if (accept) state_next = ISSUE;
      ISSUE: begin
        bus.caster_en[CASTER_IFMAP] = bus.caster_ready;
        bus.caster_en[CASTER_FLTR]  = bus.caster_ready;
        bus.caster_en[CASTER_PSUM]  = bus.caster_ready;
        if (issue_go) state_next = WAIT;
      end
      WAIT: begin
        if (wait_hit)     state_next = DRAIN;
        else if (tmo_hit) state_next = IDLE;
      end
      DRAIN: if (drain_hs) state_next = last_pass ? DONE : FETCH;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_len_reg  <= '0;
      pass_cnt_reg  <= '0;
      tmo_cnt_reg   <= '0;
      err_reg       <= 1'b0;
      ifmap_b2m_reg <= '0;
      fltr_b2m_reg  <= '0;
      psum_b2m_reg  <= '0;
      psum_out_reg  <= '0;
    end else begin
      if ((state_reg == IDLE) && start) begin
        pass_cnt_reg <= '0;
        pass_len_reg <= pass_len;
        err_reg      <= 1'b0;
      end
      if (accept) begin
        ifmap_b2m_reg <= bus.ifmap_in_data;
        fltr_b2m_reg  <= bus.fltr_in_data;
        psum_b2m_reg  <= bus.psum_in_data;
      end
      if (issue_go) tmo_cnt_reg <= '0;
      else if ((state_reg == WAIT) && !wait_hit && !tmo_hit) tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
      if (tmo_hit)  err_reg      <= 1'b1;
      if (wait_hit) psum_out_reg <= bus.psum_data_M2B;
      if (drain_hs) pass_cnt_reg <= pass_cnt_reg + 16'd1;
    end
  end

  assign bus.ifmap_in_ready = accept;
  assign bus.fltr_in_ready  = accept;
  assign bus.psum_in_ready  = accept;
  assign bus.ifmap_data_B2M = ifmap_b2m_reg;
  assign bus.fltr_data_B2M  = fltr_b2m_reg;
  assign bus.psum_data_B2M  = psum_b2m_reg;
  assign bus.psum_out_data  = psum_out_reg;
  assign bus.psum_out_valid = (state_reg == DRAIN);

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign err  = err_reg;

endmodule

// File: tb/tb_caster_bus_master.sv
// Scoreboard bench for caster_bus_master: expected B2M words, results and
// done cycles are queued by the stimulus and checked by a negedge monitor.
module tb_caster_bus_master;

  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pass_len = 16'd0;
  logic        busy, done, err;

  caster_bus_master_if #(.DATA_WIDTH(DW)) bus ();

  caster_bus_master #(.DATA_WIDTH(DW), .NUM_COL(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .pass_len(pass_len),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int en_cnt = 0, out_hs_cnt = 0, ready_pulses = 0;
  int fltr_hold = 0, rsp_delay = 1;
  bit rsp_enable = 1'b1;

  logic [15:0] q_if[$], q_fl[$];
  logic [31:0] q_ps[$];
  logic [63:0] exp_b2m_q[$];
  logic [31:0] exp_out_q[$];
  int          exp_done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One pass: source words plus the B2M triple and (optionally) result expected back.
  task automatic push_pass(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c,
                           input logic [31:0] res, input bit has_out);
    q_if.push_back(a);
    q_fl.push_back(b);
    q_ps.push_back(c);
    exp_b2m_q.push_back({a, b, c});
    if (has_out) exp_out_q.push_back(res);
  endtask

  // s = cycle number of the edge that sampled start (the FETCH/DONE cycle).
  task automatic start_job(input logic [15:0] n, output int s);
    step();
    start = 1'b1;
    pass_len = n;
    step();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("done_within_bound", seen, 1);
  endtask

  task automatic wait_en(output int e);
    bit seen = 1'b0;
    e = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.caster_en != 3'b000) begin seen = 1'b1; e = cyc; break; end
    end
    chk("en_within_bound", seen, 1);
  endtask

  task automatic wait_pov(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.psum_out_valid) begin seen = 1'b1; break; end
    end
    chk("pov_within_bound", seen, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {busy, done, err, bus.caster_en, bus.ifmap_in_ready,
                         bus.fltr_in_ready, bus.psum_in_ready, bus.psum_out_valid}, 0);
    chk({tag, "_b2m"}, {bus.ifmap_data_B2M, bus.fltr_data_B2M, bus.psum_data_B2M}, 0);
    chk({tag, "_pod"}, bus.psum_out_data, 0);
  endtask

  // Buffer-side sources; words are popped by the monitor on an observed handshake.
  initial begin
    bus.ifmap_in_valid = 1'b0; bus.ifmap_in_data = '0;
    bus.fltr_in_valid  = 1'b0; bus.fltr_in_data  = '0;
    bus.psum_in_valid  = 1'b0; bus.psum_in_data  = '0;
    forever begin
      step();
      bus.ifmap_in_valid = (q_if.size() > 0);
      bus.ifmap_in_data  = (q_if.size() > 0) ? q_if[0] : '0;
      bus.psum_in_valid  = (q_ps.size() > 0);
      bus.psum_in_data   = (q_ps.size() > 0) ? q_ps[0] : '0;
      bus.fltr_in_data   = (q_fl.size() > 0) ? q_fl[0] : '0;
      if (fltr_hold > 0) begin
        fltr_hold--;
        bus.fltr_in_valid = 1'b0;
      end else begin
        bus.fltr_in_valid = (q_fl.size() > 0);
      end
    end
  end

  // Stand-in caster: returns ifmap*fltr + psum rsp_delay cycles after the enable.
  initial begin
    logic [31:0] rsp;
    bus.caster_valid  = 1'b0;
    bus.psum_data_M2B = '0;
    forever begin
      @(negedge clk);
      if (bus.caster_en == 3'b111 && rsp_enable) begin
        rsp = 32'(bus.ifmap_data_B2M) * 32'(bus.fltr_data_B2M) + bus.psum_data_B2M;
        repeat (rsp_delay) @(posedge clk);
        #1;
        bus.caster_valid  = 1'b1;
        bus.psum_data_M2B = rsp;
        @(posedge clk);
        #1;
        bus.caster_valid  = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        pov_prev = 1'b0, por_prev = 1'b0;
    logic [31:0] pod_prev = '0;
    logic [63:0] eb;
    logic [31:0] eo;
    int          ed;
    logic        vi, vf, vp, ri, rf, rp;
    forever begin
      @(negedge clk);
      if (rst) begin
        pov_prev = 1'b0;
        por_prev = 1'b0;
      end else begin
        vi = bus.ifmap_in_valid; vf = bus.fltr_in_valid; vp = bus.psum_in_valid;
        ri = bus.ifmap_in_ready; rf = bus.fltr_in_ready; rp = bus.psum_in_ready;
        if ((vi | vf | vp) && !(vi & vf & vp)) chk("join_partial", {ri, rf, rp}, 3'b000);
        if (ri | rf | rp) begin
          chk("join_all", {ri, rf, rp, vi, vf, vp}, 6'b111111);
          ready_pulses++;
          if (ri && vi) void'(q_if.pop_front());
          if (rf && vf) void'(q_fl.pop_front());
          if (rp && vp) void'(q_ps.pop_front());
        end
        if (busy && !bus.caster_ready) chk("en_gated", bus.caster_en, 3'b000);
        if (bus.caster_en != 3'b000) begin
          en_cnt++;
          chk("en_all", bus.caster_en, 3'b111);
          chk("b2m_expected", exp_b2m_q.size() > 0, 1);
          if (exp_b2m_q.size() > 0) begin
            eb = exp_b2m_q.pop_front();
            chk("b2m_data", {bus.ifmap_data_B2M, bus.fltr_data_B2M, bus.psum_data_B2M}, eb);
          end
        end
        if (pov_prev && !por_prev) chk("out_hold", {bus.psum_out_valid, bus.psum_out_data}, {1'b1, pod_prev});
        if (bus.psum_out_valid && bus.psum_out_ready) begin
          out_hs_cnt++;
          chk("out_expected", exp_out_q.size() > 0, 1);
          if (exp_out_q.size() > 0) begin
            eo = exp_out_q.pop_front();
            chk("psum_out", bus.psum_out_data, eo);
          end
        end
        if (done) begin
          chk("done_expected", exp_done_q.size() > 0, 1);
          if (exp_done_q.size() > 0) begin
            ed = exp_done_q.pop_front();
            if (ed >= 0) chk("done_cycle", cyc, ed);
          end
        end
        pov_prev = bus.psum_out_valid;
        por_prev = bus.psum_out_ready;
        pod_prev = bus.psum_out_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, en0, oh0, rp0;
    bus.caster_ready   = 1'b1;
    bus.psum_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    step();

    // Single pass: 3*5 + 0x10 = 0x1F; valid two cycles after enable.
    // Cycles: FETCH s, ISSUE s+1, WAIT s+2..s+3, DRAIN s+4, DONE s+5.
    rsp_delay = 2;
    en0 = en_cnt; oh0 = out_hs_cnt;
    push_pass(16'h0003, 16'h0005, 32'h0000_0010, 32'h0000_001F, 1);
    start_job(16'd1, s);
    exp_done_q.push_back(s + 5);
    wait_done(40);
    chk("single_en_pulses", en_cnt - en0, 1);
    chk("single_out_hs", out_hs_cnt - oh0, 1);

    // Join: filter valid held off, all readies must pulse together once.
    rsp_delay = 1;
    rp0 = ready_pulses;
    push_pass(16'h0002, 16'h0009, 32'h0000_0001, 32'h0000_0013, 1);
    fltr_hold = 6;
    start_job(16'd1, s);
    exp_done_q.push_back(-1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("join_hold", {busy, bus.ifmap_in_ready, bus.fltr_in_ready, bus.psum_in_ready}, 4'b1000);
    end
    wait_done(40);
    chk("join_pulses", ready_pulses - rp0, 1);

    // Backpressure: caster_ready low 3 cycles, then psum_out_ready low while result waits.
    bus.caster_ready   = 1'b0;
    bus.psum_out_ready = 1'b0;
    en0 = en_cnt;
    push_pass(16'h0007, 16'h0006, 32'h0000_0020, 32'h0000_004A, 1);
    start_job(16'd1, s);
    exp_done_q.push_back(-1);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_en_low", bus.caster_en, 3'b000);
    end
    chk("bp_en_cnt", en_cnt - en0, 0);
    step();
    bus.caster_ready = 1'b1;
    wait_pov(20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_held", {bus.psum_out_valid, bus.psum_out_data}, {1'b1, 32'h0000_004A});
    end
    step();
    bus.psum_out_ready = 1'b1;
    wait_done(20);
    chk("bp_en_once", en_cnt - en0, 1);

    // Three back-to-back minimum passes: done in the 13th cycle counting FETCH as the first.
    en0 = en_cnt; oh0 = out_hs_cnt;
    push_pass(16'h0001, 16'h0002, 32'h0000_0100, 32'h0000_0102, 1);
    push_pass(16'h0004, 16'h0004, 32'h0000_0000, 32'h0000_0010, 1);
    push_pass(16'h0010, 16'h0010, 32'h0000_0001, 32'h0000_0101, 1);
    step();
    start_job(16'd3, s);
    exp_done_q.push_back(s + 12);
    wait_done(60);
    chk("multi_en_pulses", en_cnt - en0, 3);
    chk("multi_out_hs", out_hs_cnt - oh0, 3);

    // pass_len = 0: straight to DONE, no fetch, no enable.
    en0 = en_cnt; rp0 = ready_pulses;
    start_job(16'd0, s);
    exp_done_q.push_back(s);
    wait_done(10);
    chk("zero_en", en_cnt - en0, 0);
    chk("zero_ready", ready_pulses - rp0, 0);

    // Timeout: no caster_valid; 16 WAIT cycles then IDLE with err and no done.
    rsp_enable = 1'b0;
    push_pass(16'h000A, 16'h000B, 32'h0000_000C, 32'h0, 0);
    start_job(16'd1, s);
    wait_en(e);
    repeat (16) @(negedge clk);
    chk("tmo_still_wait", {busy, err}, 2'b10);
    @(negedge clk);
    chk("tmo_err_idle", {busy, err}, 2'b01);
    rsp_enable = 1'b1;
    start_job(16'd0, s);
    chk("err_cleared", err, 0);
    exp_done_q.push_back(s);
    wait_done(10);

    // Asynchronous reset during WAIT.
    rsp_delay = 30;
    push_pass(16'h0001, 16'h0001, 32'h0000_0001, 32'h0, 0);
    start_job(16'd1, s);
    wait_en(e);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    #2;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {bus.psum_out_valid, done, busy}, 3'b000);
    end
    repeat (32) @(posedge clk);
    #1;

    chk("left_b2m", exp_b2m_q.size(), 0);
    chk("left_out", exp_out_q.size(), 0);
    chk("left_done", exp_done_q.size(), 0);
    chk("left_src", q_if.size() + q_fl.size() + q_ps.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
